// File: rtl/alu_div_seq.sv
// alu_div_seq: iterative restoring divider for DIV/DIVU/REM/REMU.
// Ports:
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   Start        - request pulse, accepted only in IDLE or DONE
//   Signed, Rem  - signed op / return remainder, latched at accept
//   SrcA, SrcB   - dividend / divisor, latched at accept
//   Busy         - high in CALC and FIX
//   Done         - one-cycle pulse, Result valid
//   Result       - quotient or remainder, held until the next accept
// Divide-by-zero and signed overflow follow RISC-V M semantics and
// complete in one cycle without entering CALC.
module alu_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic             Rem,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] r_q, q_q, b_q, result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             negq_q, negr_q, rem_q, busy_q, done_q;

  // Accept-time decode
  logic             accept;
  logic             a_neg, b_neg, b_zero, ovf;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign accept = Start && (state_q == IDLE || state_q == DONE);
  assign a_neg  = Signed && SrcA[WIDTH-1];
  assign b_neg  = Signed && SrcB[WIDTH-1];
  assign a_abs  = a_neg ? (~SrcA + 1'b1) : SrcA;
  assign b_abs  = b_neg ? (~SrcB + 1'b1) : SrcB;
  assign b_zero = (SrcB == '0);
  assign ovf    = Signed && (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcB == '1);

  // One restoring step: shift {R,Q} left, trial-subtract |B|.
  // R < |B| holds between steps, so the shifted R fits in WIDTH+1 bits
  // and a successful difference fits back in WIDTH bits.
  logic [WIDTH:0]   r_sh, t_d;
  logic             t_ge;
  logic [WIDTH-1:0] r_d, q_d;

  always_comb begin
    r_sh = {r_q, q_q[WIDTH-1]};
    t_d  = r_sh - {1'b0, b_q};
    t_ge = (r_sh >= {1'b0, b_q});
    r_d  = t_ge ? t_d[WIDTH-1:0] : r_sh[WIDTH-1:0];
    q_d  = {q_q[WIDTH-2:0], t_ge};
  end

  // Sign fix-up for the FIX cycle
  logic [WIDTH-1:0] q_fix, r_fix;
  assign q_fix = negq_q ? (~q_q + 1'b1) : q_q;
  assign r_fix = negr_q ? (~r_q + 1'b1) : r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      r_q      <= '0;
      q_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      rem_q    <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            rem_q <= Rem;
            if (b_zero || ovf) begin
              // Short-circuit: result known without iterating
              if (b_zero) result_q <= Rem ? SrcA : '1;
              else        result_q <= Rem ? '0   : SrcA;
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              r_q     <= '0;
              q_q     <= a_abs;
              b_q     <= b_abs;
              cnt_q   <= '0;
              negq_q  <= a_neg ^ b_neg;
              negr_q  <= a_neg;
              state_q <= CALC;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= FIX;
        end
        FIX: begin
          result_q <= rem_q ? r_fix : q_fix;
          state_q  <= DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;

endmodule

// File: tb/tb_alu_div_seq.sv
module tb_alu_div_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         Start = 1'b0;
  logic         Signed = 1'b0;
  logic         Rem = 1'b0;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic         Busy, Done;
  logic [W-1:0] Result;

  int tests = 0;
  int fails = 0;

  alu_div_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Signed(Signed), .Rem(Rem),
    .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done), .Result(Result)
  );

  always #5 clk = ~clk;

  // Issue one operation and wait for Done (bounded). lat counts edges from
  // the accept edge (inclusive) to the edge after which Done is seen.
  task automatic run_op(input logic s, input logic r, input logic [W-1:0] a,
                        input logic [W-1:0] b, output logic [W-1:0] res,
                        output int lat, output bit busy_seen, output bit both);
    @(negedge clk);
    Start = 1'b1; Signed = s; Rem = r; SrcA = a; SrcB = b;
    lat = 0; busy_seen = 0; both = 0;
    do begin
      @(posedge clk); #1;
      Start = 1'b0;
      lat++;
      if (Busy) busy_seen = 1;
      if (Busy && Done) both = 1;
    end while (!Done && lat < 100);
    res = Result;
  endtask

  task automatic check_op(input string name, input logic s, input logic r,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input int exp_lat);
    logic [W-1:0] res; int lat; bit bs, both;
    run_op(s, r, a, b, res, lat, bs, both);
    tests++;
    if (res !== exp_res) begin
      fails++; $display("FAIL %s result: got %h expected %h", name, res, exp_res);
    end
    tests++;
    if (lat != exp_lat) begin
      fails++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    tests++;
    if (bs != (exp_lat > 1) || both) begin
      fails++; $display("FAIL %s busy: seen %0d with_done %0d expected seen %0d", name, bs, both, exp_lat > 1);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Result !== '0) begin
      fails++; $display("FAIL reset_state: got busy %b done %b result %h expected 0 0 0", Busy, Done, Result);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_unsigned();
    check_op("u_div_100_7", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 34);
    check_op("u_rem_100_7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 34);
    check_op("u_div_max_3", 1'b0, 1'b0, 32'hFFFFFFFF, 32'd3, 32'h55555555, 34);
  endtask

  task automatic test_signed();
    check_op("s_div_m7_2", 1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    check_op("s_rem_m7_2", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
    check_op("s_div_7_m2", 1'b1, 1'b0, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34);
    check_op("s_rem_7_m2", 1'b1, 1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 34);
  endtask

  task automatic test_div_zero();
    check_op("dz_u_div", 1'b0, 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    check_op("dz_u_rem", 1'b0, 1'b1, 32'd5, 32'd0, 32'd5, 1);
    check_op("dz_s_div", 1'b1, 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    check_op("dz_s_rem", 1'b1, 1'b1, 32'd5, 32'd0, 32'd5, 1);
  endtask

  task automatic test_overflow();
    check_op("ovf_s_div", 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    check_op("ovf_s_rem", 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    check_op("ovf_u_div", 1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 34);
    check_op("ovf_u_rem", 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34);
  endtask

  task automatic test_ignore_busy_start();
    int lat = 0;
    @(negedge clk);
    Start = 1'b1; Signed = 1'b0; Rem = 1'b0; SrcA = 32'd100; SrcB = 32'd7;
    do begin
      @(posedge clk); #1;
      Start = 1'b0;
      lat++;
      if (lat == 5) begin
        Start = 1'b1; Signed = 1'b1; Rem = 1'b1; SrcA = 32'd50; SrcB = 32'd3;
      end
    end while (!Done && lat < 100);
    tests++;
    if (Result !== 32'd14 || lat != 34) begin
      fails++; $display("FAIL ignore_start: got result %h lat %0d expected 0000000e lat 34", Result, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] res; int lat; bit bs, both;
    run_op(1'b0, 1'b0, 32'd100, 32'd7, res, lat, bs, both);
    // Now in the Done cycle: issue the next operation immediately
    Start = 1'b1; Signed = 1'b1; Rem = 1'b0; SrcA = 32'hFFFFFF9C; SrcB = 32'd7; // -100/7
    @(posedge clk); #1;
    Start = 1'b0;
    tests++;
    if (Busy !== 1'b1 || Done !== 1'b0) begin
      fails++; $display("FAIL b2b_busy: got busy %b done %b expected 1 0", Busy, Done);
    end
    lat = 1;
    while (!Done && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    tests++;
    if (Result !== 32'hFFFFFFF2 || lat != 34) begin
      fails++; $display("FAIL b2b_result: got %h lat %0d expected fffffff2 lat 34", Result, lat);
    end
  endtask

  task automatic test_reset_mid_calc();
    bit saw_done = 0;
    @(negedge clk);
    Start = 1'b1; Signed = 1'b0; Rem = 1'b0; SrcA = 32'd1000; SrcB = 32'd3;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1; Start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Result !== '0) begin
      fails++; $display("FAIL mid_reset_state: got busy %b done %b result %h expected 0 0 0", Busy, Done, Result);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (Done || Busy) saw_done = 1;
    end
    tests++;
    if (saw_done) begin
      fails++; $display("FAIL mid_reset_quiet: got activity 1 expected 0");
    end
    check_op("post_reset_100_7", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 34);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_ignore_busy_start();
    test_back_to_back();
    test_reset_mid_calc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
